fetch_unit: RTL

- IF stage, directly upstream of decode.
- Owns the PC register and drives the instruction-bus handshake.
- Registers the fetched word together with its PC and predicted next PC as the fetch_data_t bundle consumed by decode.
- Accepts redirects from decode (branch mispredict) and from CSR/commit (trap/mret); optional BTB supplies the predicted next PC.

---
 rtl/fetch_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
//==============================================================================
// Module   : fetch_unit (plus fetch_unit_pkg)
// Purpose  : Instruction-fetch stage. Owns the PC, runs the single-outstanding
//            instruction-bus handshake, and registers {pc, instruction,
//            predicted next PC} for decode. Redirects from CSR/commit
//            (trap/mret) and from decode (mispredict) replace the pending PC;
//            CSR has priority over BP.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            ireq_valid/ireq_addr    - fetch request, address held until data_ok
//            iresp_data_ok/iresp_data- response, completes the request
//            stallF                  - decode cannot accept, hold output
//            redirect_csr_*/bp_*     - redirect valid + target
//            bp_update_*             - resolved branch info (BTB training)
//            dataF/dataF_valid       - registered fetch bundle for decode
// Config   : `define BTB_EN enables a direct-mapped BTB (BTB_ENTRIES deep);
//            without it npc is always pc+4 and bp_update_* are ignored.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package fetch_unit_pkg;
  typedef struct packed {
    logic [63:0] pc_o;
    logic [31:0] raw_instr;
    logic [63:0] predict_pcsrc;
  } fetch_data_t;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stallF,
  input  logic        redirect_csr_valid,
  input  logic [63:0] redirect_csr_pc,
  input  logic        redirect_bp_valid,
  input  logic [63:0] redirect_bp_pc,
  input  logic        bp_update_valid,
  input  logic [63:0] bp_update_pc,
  input  logic [63:0] bp_update_target,
  input  logic        bp_update_taken,
  output fetch_data_t dataF,
  output logic        dataF_valid
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  state;
  logic [63:0] pc;        // address of the request in flight / next to issue
  logic [63:0] pend_pc;   // redirect target waiting for the dropped response
  logic [63:0] npc;       // predicted successor of pc
  logic [63:0] pc_plus4;
  logic        misaligned;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        fetch_done;
  logic [31:0] fetch_word;
  logic [63:0] fetch_npc;

  assign redirect    = redirect_csr_valid | redirect_bp_valid;
  assign redirect_pc = redirect_csr_valid ? redirect_csr_pc : redirect_bp_pc;
  assign pc_plus4    = pc + 64'd4;
  assign misaligned  = |pc[1:0];

  // A misaligned PC never reaches the bus; it completes immediately with a
  // zero word so decode can raise the misalignment exception.
  assign fetch_done = misaligned | iresp_data_ok;
  assign fetch_word = misaligned ? 32'h0 : iresp_data;
  assign fetch_npc  = misaligned ? pc_plus4 : npc;

  // Request is combinational so data_ok can return in the cycle it rises.
  assign ireq_valid = ~reset & (((state == S_FETCH) & ~misaligned) | (state == S_DISCARD));
  assign ireq_addr  = pc;

`ifdef BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 62 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [63:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_taken, up_hit;
  logic             unused_upd_lsb;

  assign lk_idx   = pc[2 +: IDX_W];
  assign lk_tag   = pc[63 -: TAG_W];
  assign up_idx   = bp_update_pc[2 +: IDX_W];
  assign up_tag   = bp_update_pc[63 -: TAG_W];
  assign unused_upd_lsb = ^bp_update_pc[1:0];

  // Counter MSB set means "weakly/strongly taken" (counter >= 2).
  assign lk_taken = btb_valid[lk_idx] & (btb_tag[lk_idx] == lk_tag) & btb_ctr[lk_idx][1];
  assign up_hit   = btb_valid[up_idx] & (btb_tag[up_idx] == up_tag);
  assign npc      = lk_taken ? btb_target[lk_idx] : pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
    end else if (bp_update_valid && !up_hit && bp_update_taken) begin
      btb_valid[up_idx] <= 1'b1;
    end
  end

  // Entry payload needs no reset: it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (!reset && bp_update_valid) begin
      if (up_hit) begin
        if (bp_update_taken) begin
          if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
          btb_target[up_idx] <= bp_update_target;
        end else if (btb_ctr[up_idx] != 2'b00) begin
          btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
        end
      end else if (bp_update_taken) begin
        btb_tag[up_idx]    <= up_tag;
        btb_target[up_idx] <= bp_update_target;
        btb_ctr[up_idx]    <= 2'b10;
      end
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_update_valid, bp_update_pc, bp_update_target,
                       bp_update_taken, (BTB_ENTRIES == 0)};
  assign npc = pc_plus4;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      pend_pc     <= RESET_PC;
      dataF       <= '0;
      dataF_valid <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (redirect) begin
            dataF_valid <= 1'b0;
            if (fetch_done) begin
              pc <= redirect_pc;          // response (if any) is simply dropped
            end else begin
              pend_pc <= redirect_pc;     // must still absorb the in-flight response
              state   <= S_DISCARD;
            end
          end else if (fetch_done) begin
            dataF       <= {pc, fetch_word, fetch_npc};
            dataF_valid <= 1'b1;
            if (stallF) state <= S_HOLD;
            else        pc    <= fetch_npc;
          end else if (!stallF) begin
            dataF_valid <= 1'b0;          // previous output consumed, nothing new
          end
        end
        S_HOLD: begin
          if (redirect) begin
            dataF_valid <= 1'b0;
            pc          <= redirect_pc;
            state       <= S_FETCH;
          end else if (!stallF) begin
            // Use the prediction made at capture time so a BTB update during
            // the stall cannot make pc disagree with predict_pcsrc.
            dataF_valid <= 1'b0;
            pc          <= dataF.predict_pcsrc;
            state       <= S_FETCH;
          end
        end
        S_DISCARD: begin
          dataF_valid <= 1'b0;
          if (iresp_data_ok) begin
            pc    <= redirect ? redirect_pc : pend_pc;
            state <= S_FETCH;
          end else if (redirect) begin
            pend_pc <= redirect_pc;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire
